// File: rtl/jtbubl_colmix.sv
// jtbubl_colmix: colour mixer behind the tile/object line buffer.
//
// Each pixel's 8-bit palette index selects a 16-bit RGB444 entry held as two
// bytes in a 512x8 CPU-writable palette RAM:
//   byte 2n   = {R,G}
//   byte 2n+1 = {B,unused}
// A four-state fetch FSM reads both bytes through the single video read port
// between pixel clock enables. The finished colour goes out on the following
// pxl_cen, gated by the blanking sampled with that index. It then passes through
// BLANK_DLY extra pxl_cen stages, which are shared with the delayed blanking.
//
// Parameters:
//   SIMFILE   - name of a hex preload image for simulation environments that
//               back-door load the palette array; the RTL keeps no initial block
//   BLANK_DLY - extra pxl_cen stages on RGB and blanking (0..3)
//
// Ports:
//   rst, clk              async active-high reset, system clock
//   pxl_cen               one-clk pixel enable, period >= 4 clk
//   LHBL, LVBL            active-low blanking, aligned with col_addr
//   col_addr              palette index, sampled on pxl_cen
//   pal_cs, cpu_rnw       CPU palette select, read(1)/write(0)
//   cpu_addr, cpu_dout    CPU byte address and write data
//   pal_dout              CPU read data (registered)
//   red, green, blue      4-bit colour outputs
//   LHBL_dly, LVBL_dly    blanking delayed to match RGB
//
// Optional feature macro: JTBUBL_PALREAD_EN
//   defined   - CPU reads return the palette byte one clk later
//   undefined - the palette is write-only from the CPU and pal_dout is 8'hff
module jtbubl_colmix #(
  parameter     SIMFILE   = "",
  parameter int BLANK_DLY = 0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [7:0] col_addr,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, DONE} st_t;
  typedef logic [13:0] pix_t;   // {rgb[11:0], hb, vb}

  // ---------------------------------------------------------------------------
  // Palette RAM. Port A is the CPU port and port B is the video port. Both
  // ports read with 1 clk latency. When the CPU writes an address in the same
  // clk that the video port reads it, the video port gets the old byte.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:511];
  logic [8:0] addr_b_q;
  logic [7:0] q_b_q;

  always_ff @(posedge clk) begin
    if (pal_cs && !cpu_rnw) mem[cpu_addr] <= cpu_dout;
    q_b_q <= mem[addr_b_q];
  end

`ifdef JTBUBL_PALREAD_EN
  // The port-A read register doubles as pal_dout. It holds its value until
  // the next CPU read.
  logic [7:0] pal_dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      pal_dout_q <= 8'hff;
    else if (pal_cs && cpu_rnw)   pal_dout_q <= mem[cpu_addr];
  end

  assign pal_dout = pal_dout_q;
`else
  assign pal_dout = 8'hff;
`endif

  // ---------------------------------------------------------------------------
  // Fetch FSM. pxl_cen restarts the fetch from any state, so a pixel clock
  // that is too fast never hangs the FSM. The colour is committed to col_q
  // only in DONE, which means an aborted fetch leaves the last completed entry
  // in col_q.
  // ---------------------------------------------------------------------------
  st_t         st_q;
  logic [7:0]  idx_q;
  logic [7:0]  rg_q;
  logic [11:0] col_q;
  logic        hb_q, vb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      idx_q    <= 8'd0;
      rg_q     <= 8'd0;
      col_q    <= 12'd0;
      hb_q     <= 1'b0;
      vb_q     <= 1'b0;
      addr_b_q <= 9'd0;
    end else if (pxl_cen) begin
      idx_q    <= col_addr;
      hb_q     <= LHBL;
      vb_q     <= LVBL;
      addr_b_q <= {col_addr, 1'b0};
      st_q     <= RD_HI;
    end else begin
      case (st_q)
        RD_HI: begin
          addr_b_q <= {idx_q, 1'b1};
          st_q     <= RD_LO;
        end
        RD_LO: begin
          rg_q <= q_b_q;                   // even byte, requested in RD_HI
          st_q <= DONE;
        end
        DONE:  col_q <= {rg_q, q_b_q[7:4]}; // odd byte; low nibble unused
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage plus BLANK_DLY extra stages, all advanced on pxl_cen. The RGB
  // is forced to zero when either blanking signal is active.
  // ---------------------------------------------------------------------------
  pix_t dly_q [0:BLANK_DLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= BLANK_DLY; i++) dly_q[i] <= '0;
    end else if (pxl_cen) begin
      dly_q[0] <= {(hb_q && vb_q) ? col_q : 12'h000, hb_q, vb_q};
      for (int i = 1; i <= BLANK_DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign {red, green, blue, LHBL_dly, LVBL_dly} = dly_q[BLANK_DLY];

endmodule

// File: tb/tb_jtbubl_colmix.sv
module tb_jtbubl_colmix;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, LHBL, LVBL, pal_cs, cpu_rnw;
  logic [7:0] col_addr, cpu_dout;
  logic [8:0] cpu_addr;
  wire  [7:0] pal_dout, pal_dout2;
  wire  [3:0] red, green, blue, red2, green2, blue2;
  wire        hb_o, vb_o, hb2_o, vb2_o;

  always #5 clk = ~clk;

  jtbubl_colmix #(.BLANK_DLY(0)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .col_addr(col_addr), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
    .red(red), .green(green), .blue(blue), .LHBL_dly(hb_o), .LVBL_dly(vb_o)
  );

  jtbubl_colmix #(.BLANK_DLY(2)) dut2 (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .col_addr(col_addr), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout2),
    .red(red2), .green(green2), .blue(blue2), .LHBL_dly(hb2_o), .LVBL_dly(vb2_o)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
  } exp_t;

  typedef struct {
    logic [7:0] idx;
    logic       hb;
    logic       vb;
    exp_t       exp;
  } vec_t;

  vec_t       tab [10];
  exp_t       q0[$], q2[$];
  logic [7:0] mdl [512];
  int         n_vec = 0;
  int         n_err = 0;

`ifdef JTBUBL_PALREAD_EN
  localparam logic [7:0] RD_EXP = 8'hA5;
`else
  localparam logic [7:0] RD_EXP = 8'hff;
`endif

  function automatic logic [11:0] pal(input logic [7:0] idx);
    logic [7:0] ev, od;
    ev = mdl[{idx, 1'b0}];
    od = mdl[{idx, 1'b1}];
    return {ev, od[7:4]};
  endfunction

  function automatic exp_t mk(input logic hb, input logic vb, input logic [11:0] col);
    exp_t e;
    e.rgb = (hb && vb) ? col : 12'h000;
    e.hb  = hb;
    e.vb  = vb;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Outputs after a pxl_cen: DUT0 shows the previous pixel, DUT2 shows the
  // pixel three samples back.
  task automatic check_out();
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("rgb_dly0", {2'b0, red, green, blue, hb_o, vb_o}, {2'b0, e});
    end
    if (q2.size() >= 3) begin
      e = q2.pop_front();
      chk("rgb_dly2", {2'b0, red2, green2, blue2, hb2_o, vb2_o}, {2'b0, e});
    end
  endtask

  // One pixel: pulse pxl_cen, check outputs, queue this pixel's expectation,
  // then idle until the gap (in clk) has passed. An optional CPU write is
  // presented in the clk right after pxl_cen, colliding with the even-byte read.
  task automatic pixel(input logic [7:0] idx, input logic hb, input logic vb,
                       input int gap, input exp_t e, input logic wr,
                       input logic [8:0] wa, input logic [7:0] wd);
    col_addr = idx; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    check_out();
    q0.push_back(e);
    q2.push_back(e);
    if (wr) begin
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = wa; cpu_dout = wd;
    end
    for (int i = 1; i < gap; i++) begin
      @(posedge clk); #1;
      pal_cs = 1'b0;
    end
  endtask

  task automatic pixel_n(input logic [7:0] idx, input logic hb, input logic vb);
    pixel(idx, hb, vb, 4, mk(hb, vb, pal(idx)), 1'b0, 9'd0, 8'd0);
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    @(posedge clk); #1;
    pal_cs = 1'b0;
    mdl[a] = d;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rgb0"}, {2'b0, red, green, blue, hb_o, vb_o}, 16'h0);
    chk({name, "_rgb2"}, {2'b0, red2, green2, blue2, hb2_o, vb2_o}, 16'h0);
    chk({name, "_pal"}, {8'h0, pal_dout}, 16'h00ff);
  endtask

  initial begin
    logic [7:0] ids [5];
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0; col_addr = 8'd0;
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 9'd0; cpu_dout = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Palette contents
    cpu_wr(9'h021, 8'hA5);
    cpu_wr(9'h020, 8'h3C);
    ids = '{8'h01, 8'h02, 8'h7F, 8'hFF, 8'h00};
    foreach (ids[i]) begin
      cpu_wr({ids[i], 1'b0}, 8'($urandom));
      cpu_wr({ids[i], 1'b1}, 8'($urandom));
    end

    // Vector table: index and blanking with the expected output
    tab[0] = '{8'h10, 1'b1, 1'b1, '{12'h3CA, 1'b1, 1'b1}};
    tab[1] = '{8'h01, 1'b1, 1'b1, mk(1'b1, 1'b1, pal(8'h01))};
    tab[2] = '{8'h02, 1'b1, 1'b1, mk(1'b1, 1'b1, pal(8'h02))};
    tab[3] = '{8'h7F, 1'b1, 1'b1, mk(1'b1, 1'b1, pal(8'h7F))};
    tab[4] = '{8'hFF, 1'b1, 1'b1, mk(1'b1, 1'b1, pal(8'hFF))};
    tab[5] = '{8'h10, 1'b0, 1'b1, '{12'h000, 1'b0, 1'b1}};
    tab[6] = '{8'h10, 1'b1, 1'b0, '{12'h000, 1'b1, 1'b0}};
    tab[7] = '{8'h00, 1'b1, 1'b1, mk(1'b1, 1'b1, pal(8'h00))};
    tab[8] = '{8'hFF, 1'b0, 1'b0, '{12'h000, 1'b0, 1'b0}};
    tab[9] = '{8'h10, 1'b1, 1'b1, '{12'h3CA, 1'b1, 1'b1}};
    foreach (tab[i]) pixel(tab[i].idx, tab[i].hb, tab[i].vb, 4, tab[i].exp, 1'b0, 9'd0, 8'd0);

    // CPU write collides with the even-byte read: old R/G now, new R/G next time
    pixel(8'h10, 1'b1, 1'b1, 4, '{12'h3CA, 1'b1, 1'b1}, 1'b1, 9'h020, 8'h5B);
    mdl[9'h020] = 8'h5B;
    pixel(8'h10, 1'b1, 1'b1, 4, '{12'h5BA, 1'b1, 1'b1}, 1'b0, 9'd0, 8'd0);

    // pxl_cen every 3 clk: fetches never finish, so the output keeps the last
    // completed entry (0x10) while the blanking follows each sample
    pixel(8'h01, 1'b1, 1'b1, 3, mk(1'b1, 1'b1, 12'h5BA), 1'b0, 9'd0, 8'd0);
    pixel(8'h02, 1'b1, 1'b1, 3, mk(1'b1, 1'b1, 12'h5BA), 1'b0, 9'd0, 8'd0);
    pixel(8'h01, 1'b1, 1'b0, 3, mk(1'b1, 1'b0, 12'h5BA), 1'b0, 9'd0, 8'd0);
    pixel(8'h02, 1'b1, 1'b1, 3, mk(1'b1, 1'b1, 12'h5BA), 1'b0, 9'd0, 8'd0);
    pixel_n(8'h02, 1'b1, 1'b1);
    pixel_n(8'h01, 1'b1, 1'b1);

    // Reset while the FSM is in RD_LO
    col_addr = 8'h10; LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    check_out();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q2.delete();
    @(posedge clk); #1;

    // CPU read path
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h021;
    #1;
    chk("pal_rd_pre", {8'h0, pal_dout}, 16'h00ff);
    @(posedge clk); #1;
    pal_cs = 1'b0; cpu_addr = 9'h020;
    chk("pal_rd", {8'h0, pal_dout}, {8'h0, RD_EXP});
    @(posedge clk); #1;
    chk("pal_hold", {8'h0, pal_dout}, {8'h0, RD_EXP});

    // Palette survives reset
    pixel_n(8'h10, 1'b1, 1'b1);
    pixel_n(8'h7F, 1'b1, 1'b1);
    pixel_n(8'h00, 1'b0, 1'b1);
    pixel_n(8'h02, 1'b1, 1'b1);
    pixel_n(8'h00, 1'b1, 1'b1);
    pixel_n(8'h00, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
